// File: rtl/sdram_init_if.sv
// rtl/sdram_init_if.sv - SDRAM init command bus between the sequencer and the controller command mux
interface sdram_init_if #(
  parameter int ADDR_W = 11,
  parameter int BA_W   = 2
);
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic [BA_W-1:0]   init_ba;
  logic              init_cke;
  logic              init_done;

  modport master (
    output init_cmd, init_addr, init_ba, init_cke, init_done
  );

  modport slave (
    input init_cmd, init_addr, init_ba, init_cke, init_done
  );
endinterface

// File: rtl/sdram_init.sv
// rtl/sdram_init.sv - SDR SDRAM power-up initialisation sequencer
module sdram_init #(
  parameter int                ADDR_W        = 11,
  parameter int                BA_W          = 2,
  parameter int                T_POWERUP_CYC = 20000,
  parameter int                T_RP_CYC      = 2,
  parameter int                T_RFC_CYC     = 7,
  parameter int                T_MRD_CYC     = 2,
  parameter int                AREF_NUM      = 2,
  parameter logic [ADDR_W-1:0] MODE_REG      = 11'h032
) (
  input  logic          clk,
  input  logic          rst,
  sdram_init_if.master  init_bus
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam int MAX_A = (T_POWERUP_CYC > T_RP_CYC)  ? T_POWERUP_CYC : T_RP_CYC;
  localparam int MAX_B = (T_RFC_CYC     > T_MRD_CYC) ? T_RFC_CYC     : T_MRD_CYC;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_T) + 1;
  localparam int REF_W = $clog2(AREF_NUM + 1);

  // Wait states are entered one cycle after their command, so a T-cycle
  // spacing needs T-1 wait cycles, i.e. the counter ends at T-2.
  localparam logic [CNT_W-1:0] PU_END  = CNT_W'(T_POWERUP_CYC);
  localparam logic [CNT_W-1:0] RP_END  = CNT_W'(T_RP_CYC - 2);
  localparam logic [CNT_W-1:0] RFC_END = CNT_W'(T_RFC_CYC - 2);
  localparam logic [CNT_W-1:0] MRD_END = CNT_W'(T_MRD_CYC - 2);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(AREF_NUM);
  localparam logic [ADDR_W-1:0] PRE_ALL_ADDR = ADDR_W'(1) << 10;

  typedef enum logic [2:0] {
    S_WAIT_PU,
    S_PRE,
    S_WAIT_RP,
    S_AREF,
    S_WAIT_RFC,
    S_LMR,
    S_WAIT_MRD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic              cke_q, cke_d;
  logic              done_q, done_d;

  // Next state, counters and the registered outputs of the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    ref_d   = ref_q;

    case (state_q)
      S_WAIT_PU:  if (cnt_q == PU_END) state_d = S_PRE;
      S_PRE:      state_d = S_WAIT_RP;
      S_WAIT_RP:  if (cnt_q == RP_END) state_d = S_AREF;
      S_AREF: begin
        state_d = S_WAIT_RFC;
        ref_d   = ref_q + 1'b1;
      end
      S_WAIT_RFC: if (cnt_q == RFC_END) state_d = (ref_q < REF_MAX) ? S_AREF : S_LMR;
      S_LMR:      state_d = S_WAIT_MRD;
      S_WAIT_MRD: if (cnt_q == MRD_END) state_d = S_DONE;
      S_DONE:     cnt_d = cnt_q;
      default:    state_d = S_WAIT_PU;
    endcase

    // Counters restart on every state entry, so they never need to wrap.
    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_PRE)   ref_d = '0;

    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    cke_d  = 1'b1;
    done_d = 1'b0;
    case (state_d)
      S_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = PRE_ALL_ADDR;
      end
      S_AREF:  cmd_d = CMD_REF;
      S_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT_PU;
      cnt_q   <= '0;
      ref_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      cke_q   <= cke_d;
      done_q  <= done_d;
    end
  end

  assign init_bus.init_cmd  = cmd_q;
  assign init_bus.init_addr = addr_q;
  assign init_bus.init_ba   = ba_q;
  assign init_bus.init_cke  = cke_q;
  assign init_bus.init_done = done_q;

endmodule

// File: tb/tb_sdram_init.sv
// tb/tb_sdram_init.sv - randomized reset-episode bench for sdram_init against a timeline model
module tb_sdram_init;

  localparam int A_TPU = 10, A_TRP = 2, A_TRFC = 7, A_TMRD = 2, A_AN = 2;
  localparam int B_TPU = 10, B_TRP = 2, B_TRFC = 9, B_TMRD = 2, B_AN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_init_if if_a ();
  sdram_init_if if_b ();

  sdram_init #(.T_POWERUP_CYC(A_TPU), .T_RFC_CYC(A_TRFC), .AREF_NUM(A_AN)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .init_bus (if_a.master)
  );

  sdram_init #(.T_POWERUP_CYC(B_TPU), .T_RFC_CYC(B_TRFC), .AREF_NUM(B_AN)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .init_bus (if_b.master)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ncmd_a = 0;
  int ncmd_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected bus contents in cycle n after reset release, from the command timeline.
  task automatic model(input int n, input int tpu, input int trp, input int trfc,
                       input int tmrd, input int an,
                       output logic [3:0] cmd, output logic [10:0] addr,
                       output logic cke, output logic done);
    int p, l;
    cmd  = 4'b0111;
    addr = 11'h000;
    cke  = (n >= 1);
    p    = tpu + 1;
    l    = p + trp + an * trfc;
    if (n == p) begin
      cmd  = 4'b0010;
      addr = 11'h400;
    end
    for (int k = 0; k < an; k++)
      if (n == p + trp + k * trfc) cmd = 4'b0001;
    if (n == l) begin
      cmd  = 4'b0000;
      addr = 11'h032;
    end
    done = (n >= l + tmrd);
  endtask

  task automatic check_dut(input string name, input int tpu, input int trp, input int trfc,
                           input int tmrd, input int an,
                           input logic [3:0] cmd, input logic [10:0] addr, input logic [1:0] ba,
                           input logic cke, input logic done);
    logic [3:0]  e_cmd;
    logic [10:0] e_addr;
    logic        e_cke, e_done;
    model(cyc, tpu, trp, trfc, tmrd, an, e_cmd, e_addr, e_cke, e_done);
    check({name, ".cmd"},  32'(cmd),  32'(e_cmd));
    check({name, ".addr"}, 32'(addr), 32'(e_addr));
    check({name, ".ba"},   32'(ba),   32'd0);
    check({name, ".cke"},  32'(cke),  32'(e_cke));
    check({name, ".done"}, 32'(done), 32'(e_done));
  endtask

  // One clock: track the cycle index, check both DUTs mid-cycle, then drive rst.
  task automatic step(input logic rst_next);
    @(posedge clk);
    if (rst) begin
      cyc    = 0;
      ncmd_a = 0;
      ncmd_b = 0;
    end else begin
      cyc++;
    end
    @(negedge clk);
    check_dut("a", A_TPU, A_TRP, A_TRFC, A_TMRD, A_AN,
              if_a.init_cmd, if_a.init_addr, if_a.init_ba, if_a.init_cke, if_a.init_done);
    check_dut("b", B_TPU, B_TRP, B_TRFC, B_TMRD, B_AN,
              if_b.init_cmd, if_b.init_addr, if_b.init_ba, if_b.init_cke, if_b.init_done);
    if (if_a.init_cmd != 4'b0111) ncmd_a++;
    if (if_b.init_cmd != 4'b0111) ncmd_b++;
    rst = rst_next;
  endtask

  // Hold reset for rlen edges, then run runlen cycles; total command count once done.
  task automatic episode(input int rlen, input int runlen);
    rst = 1'b1;
    for (int i = 0; i < rlen + runlen; i++) step((i + 1 < rlen) ? 1'b1 : 1'b0);
    if (cyc >= A_TPU + 1 + A_TRP + A_AN * A_TRFC + A_TMRD) check("a.ncmd", ncmd_a, 2 + A_AN);
    if (cyc >= B_TPU + 1 + B_TRP + B_AN * B_TRFC + B_TMRD) check("b.ncmd", ncmd_b, 2 + B_AN);
  endtask

  initial begin
    @(negedge clk);
    episode(3, 100);
    episode(1, 15);
    episode(1, 100);
    episode(2, 40);
    episode(1, 40);
    for (int e = 0; e < 10; e++)
      episode(int'($urandom_range(1, 3)), int'($urandom_range(1, 110)));
    episode(1, 95);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
